// File: rtl/ram_fifo_master.sv
// rtl/ram_fifo_master.sv - byte-stream FIFO client driving the RAM write/read request handshakes
module ram_fifo_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              write,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    input  logic              WriteReady,
    output logic              read,
    output logic [ADDR_W-1:0] ReadAddr,
    input  logic [DATA_W-1:0] ReadData,
    input  logic              ReadReady,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {W_IDLE, W_BUSY} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_BUSY, R_HOLD} rstate_t;

    wstate_t           wState;
    rstate_t           rState;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              wDone;
    logic              rDone;

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign in_ready = !rst && (wState == W_IDLE) && !full;
    assign wDone    = (wState == W_BUSY) && WriteReady;
    assign rDone    = (rState == R_BUSY) && ReadReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wState    <= W_IDLE;
            rState    <= R_IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            write     <= 1'b0;
            WriteAddr <= '0;
            WriteData <= '0;
            read      <= 1'b0;
            ReadAddr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (wState)
                W_IDLE: begin
                    if (in_valid && !full) begin
                        write     <= 1'b1;
                        WriteAddr <= wptr;
                        WriteData <= in_data;
                        wState    <= W_BUSY;
                    end
                end
                W_BUSY: begin
                    if (WriteReady) begin
                        write  <= 1'b0;
                        wptr   <= wptr + 1'b1;
                        wState <= W_IDLE;
                    end
                end
                default: wState <= W_IDLE;
            endcase

            // count only covers committed bytes, so a read never targets an in-flight write
            case (rState)
                R_IDLE: begin
                    if (count != '0) begin
                        read     <= 1'b1;
                        ReadAddr <= rptr;
                        rState   <= R_BUSY;
                    end
                end
                R_BUSY: begin
                    if (ReadReady) begin
                        read      <= 1'b0;
                        out_data  <= ReadData;
                        out_valid <= 1'b1;
                        rptr      <= rptr + 1'b1;
                        rState    <= R_HOLD;
                    end
                end
                R_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rState    <= R_IDLE;
                    end
                end
                default: rState <= R_IDLE;
            endcase

            if (wDone && !rDone) begin
                count <= count + 1'b1;
            end else if (!wDone && rDone) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_fifo_master.sv
// tb/tb_ram_fifo_master.sv - self-checking bench for ram_fifo_master with a RAM model and order scoreboard
module tb_ram_fifo_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       write;
    logic [3:0] WriteAddr;
    logic [7:0] WriteData;
    logic       WriteReady = 1'b0;
    logic       read;
    logic [3:0] ReadAddr;
    logic [7:0] ReadData;
    logic       ReadReady = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int tests = 0;
    int fails = 0;
    logic [7:0] sentQ[$];
    int wDone = 0;
    int rDone = 0;
    int accepted = 0;
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    ram_fifo_master #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .write(write), .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteReady(WriteReady),
        .read(read), .ReadAddr(ReadAddr), .ReadData(ReadData), .ReadReady(ReadReady),
        .count(count), .full(full), .empty(empty)
    );

    always @(posedge clk) begin
        if (write && WriteReady) mem[WriteAddr] <= WriteData;
    end
    assign ReadData = mem[ReadAddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: classify the handshakes seen before the edge, update the model, then check occupancy.
    task automatic cyc();
        logic acc, wd, rd, pp;
        logic [7:0] expB;
        acc = in_valid && in_ready;
        wd  = write && WriteReady;
        rd  = read && ReadReady;
        pp  = out_valid && out_ready;
        if (acc) begin
            sentQ.push_back(in_data);
            accepted++;
        end
        if (wd) begin
            check("write_addr", {28'd0, WriteAddr}, wDone % 16);
            wDone++;
        end
        if (rd) begin
            check("read_addr", {28'd0, ReadAddr}, rDone % 16);
            rDone++;
        end
        if (pp) begin
            check("out_extra", sentQ.size() != 0, 1);
            if (sentQ.size() != 0) begin
                expB = sentQ.pop_front();
                check("out_data", out_data, expB);
            end
        end
        @(negedge clk);
        check("count", count, wDone - rDone);
        check("full", full, (wDone - rDone) == 16);
        check("empty", empty, (wDone - rDone) == 0);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            cyc();
            done = (sentQ.size() == 0) && !out_valid && !read && !write;
        end
        check("drain_done", done, 1);
    endtask

    task automatic send(input logic [7:0] b);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !got; k++) begin
            got = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        check("send_accept", got, 1);
    endtask

    initial begin
        int base;
        // reset and idle
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_write", write, 0);
        check("rst_read", read, 0);
        check("rst_waddr", WriteAddr, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_raddr", ReadAddr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("idle_write", write, 0);
            check("idle_read", read, 0);
        end

        // single byte with RAM readies high: latency N+1 / N+2 / N+3
        WriteReady = 1'b1;
        ReadReady  = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hA5;
        cyc();
        in_valid = 1'b0;
        check("a5_write", write, 1);
        check("a5_waddr", WriteAddr, 0);
        check("a5_wdata", WriteData, 8'hA5);
        cyc();
        check("a5_write_done", write, 0);
        check("a5_count1", count, 1);
        cyc();
        check("a5_read", read, 1);
        check("a5_raddr", ReadAddr, 0);
        check("a5_no_out_yet", out_valid, 0);
        cyc();
        check("a5_out_valid", out_valid, 1);
        check("a5_out_data", out_data, 8'hA5);
        check("a5_count0", count, 0);
        cyc();
        check("a5_out_drop", out_valid, 0);

        // write stall
        WriteReady = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h3C;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_write", write, 1);
            check("stall_waddr", WriteAddr, 1);
            check("stall_wdata", WriteData, 8'h3C);
            check("stall_in_ready", in_ready, 0);
            check("stall_count", count, 0);
            cyc();
        end
        WriteReady = 1'b1;
        cyc();
        check("stall_done_write", write, 0);
        check("stall_done_count", count, 1);
        drain();

        // fill to full with reads blocked
        ReadReady = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i));
        cyc();
        check("fill_count", count, 16);
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            check("full_in_ready", in_ready, 0);
            check("full_no_write", write, 0);
            cyc();
        end
        in_valid  = 1'b0;
        ReadReady = 1'b1;
        out_ready = 1'b1;
        drain();
        check("fill_drained_empty", empty, 1);

        // random stream with random readies, wrapping the address space
        base = accepted;
        for (int c = 0; c < 4000 && (accepted - base) < 40; c++) begin
            in_valid   = ($urandom_range(0, 1) == 1);
            in_data    = 8'($urandom);
            WriteReady = ($urandom_range(0, 1) == 1);
            ReadReady  = ($urandom_range(0, 1) == 1);
            out_ready  = ($urandom_range(0, 1) == 1);
            cyc();
        end
        in_valid = 1'b0;
        check("rand_accepted", accepted - base, 40);
        WriteReady = 1'b1;
        ReadReady  = 1'b1;
        out_ready  = 1'b1;
        drain();

        // reset while both requests are outstanding
        send(8'h11);
        cyc();
        WriteReady = 1'b0;
        ReadReady  = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h22;
        cyc();
        in_valid = 1'b0;
        check("pre_rst_write", write, 1);
        check("pre_rst_read", read, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_write", write, 0);
        check("async_rst_read", read, 0);
        check("async_rst_count", count, 0);
        check("async_rst_in_ready", in_ready, 0);
        sentQ.delete();
        wDone = 0;
        rDone = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        WriteReady = 1'b1;
        ReadReady  = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h5A;
        cyc();
        in_valid = 1'b0;
        check("post_rst_waddr", WriteAddr, 0);
        check("post_rst_wdata", WriteData, 8'h5A);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
